// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants, FSM states and packing helper.
// Imported by the sequential subtractor and the alignment shifter.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;

   localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
   localparam logic [31:0]      FP32_QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADDSUB,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Pack a result; a widened exponent at or above 255 saturates to Inf.
   function automatic logic [31:0] pack_fp32(
      input logic              s,
      input logic [EXP_W:0]    e,
      input logic [FRAC_W-1:0] f
   );
      if (e >= 9'd255)
         return {s, EXP_MAX, 23'h0};
      return {s, e[EXP_W-1:0], f};
   endfunction

endpackage

// File: rtl/fp32_align_shift.sv
// Swap two FP32 operands by magnitude and right-align the smaller one.
// Shifts of 24 or more saturate to zero; shifted-out bits are truncated.
module fp32_align_shift
   import fp32_pkg::*;
(
   input  fp32_t             op_x,
   input  fp32_t             op_y,
   output logic              sign_l,
   output logic              sign_s,
   output logic [EXP_W-1:0]  exp_l,
   output logic [MANT_W-1:0] mant_l,
   output logic [MANT_W-1:0] mant_s
);

   logic [MANT_W-1:0] mx;
   logic [MANT_W-1:0] my;
   logic [MANT_W-1:0] ms_raw;
   logic [EXP_W-1:0]  es;
   logic [EXP_W-1:0]  diff;
   logic              swap;

   // Zero-exponent operands carry no implicit one; order, then shift.
   always_comb begin
      mx     = (op_x.exp == '0) ? '0 : {1'b1, op_x.frac};
      my     = (op_y.exp == '0) ? '0 : {1'b1, op_y.frac};
      swap   = {op_y.exp, my} > {op_x.exp, mx};
      sign_l = op_x.sign;
      sign_s = op_y.sign;
      exp_l  = op_x.exp;
      es     = op_y.exp;
      mant_l = mx;
      ms_raw = my;
      if (swap) begin
         sign_l = op_y.sign;
         sign_s = op_x.sign;
         exp_l  = op_y.exp;
         es     = op_x.exp;
         mant_l = my;
         ms_raw = mx;
      end
      diff   = exp_l - es;
      mant_s = (diff >= 8'd24) ? '0 : (ms_raw >> diff);
   end

endmodule

// File: rtl/fp32_subtractor_seq.sv
// Multi-cycle FP32 subtractor (a - b), truncating, one-bit-per-cycle normalise.
// Define FP32_SUB_SPECIALS_EN to add NaN/Inf handling in ALIGN.
module fp32_subtractor_seq
   import fp32_pkg::*;
#(
   parameter logic ZERO_SIGN = 1'b0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   state_t state;
   state_t state_nx;

   fp32_t             op_a;
   fp32_t             op_b;
   logic              sign_l_r;
   logic              sign_s_r;
   logic [EXP_W:0]    exp_r;
   logic [MANT_W-1:0] mant_l_r;
   logic [MANT_W-1:0] mant_s_r;
   logic [MANT_W:0]   sum_r;
   logic [31:0]       result_r;

   logic              al_sign_l;
   logic              al_sign_s;
   logic [EXP_W-1:0]  al_exp_l;
   logic [MANT_W-1:0] al_mant_l;
   logic [MANT_W-1:0] al_mant_s;
   logic              norm_done;

   fp32_align_shift u_align (
      .op_x   (op_a),
      .op_y   (op_b),
      .sign_l (al_sign_l),
      .sign_s (al_sign_s),
      .exp_l  (al_exp_l),
      .mant_l (al_mant_l),
      .mant_s (al_mant_s)
   );

   assign norm_done = sum_r[MANT_W] | (sum_r == '0) |
                      sum_r[MANT_W-1] | (exp_r <= 9'd1);

`ifdef FP32_SUB_SPECIALS_EN
   logic        spec_hit;
   logic [31:0] spec_res;
   logic        nan_a;
   logic        nan_b;
   logic        inf_a;
   logic        inf_b;

   // Detect NaN/Inf operands; b already carries its effective sign.
   always_comb begin
      nan_a    = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
      nan_b    = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
      inf_a    = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
      inf_b    = (op_b.exp == EXP_MAX) && (op_b.frac == '0);
      spec_hit = (op_a.exp == EXP_MAX) || (op_b.exp == EXP_MAX);
      spec_res = FP32_QNAN;
      if (nan_a || nan_b)
         spec_res = FP32_QNAN;
      else if (inf_a && inf_b)
         spec_res = (op_a.sign == op_b.sign) ?
                    {op_a.sign, EXP_MAX, 23'h0} : FP32_QNAN;
      else if (inf_a)
         spec_res = {op_a.sign, EXP_MAX, 23'h0};
      else if (inf_b)
         spec_res = {op_b.sign, EXP_MAX, 23'h0};
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (in_valid) state_nx = ALIGN;
`ifdef FP32_SUB_SPECIALS_EN
         ALIGN:  state_nx = spec_hit ? DONE : ADDSUB;
`else
         ALIGN:  state_nx = ADDSUB;
`endif
         ADDSUB: state_nx = NORM;
         NORM:   if (norm_done) state_nx = DONE;
         DONE:   if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   assign result = result_r;

   // Datapath: capture, align, add/sub, normalise and pack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         sign_l_r <= 1'b0;
         sign_s_r <= 1'b0;
         exp_r    <= '0;
         mant_l_r <= '0;
         mant_s_r <= '0;
         sum_r    <= '0;
         result_r <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a <= a;
                  op_b <= {~b[31], b[30:0]};
               end
            end
            ALIGN: begin
               sign_l_r <= al_sign_l;
               sign_s_r <= al_sign_s;
               exp_r    <= {1'b0, al_exp_l};
               mant_l_r <= al_mant_l;
               mant_s_r <= al_mant_s;
`ifdef FP32_SUB_SPECIALS_EN
               if (spec_hit)
                  result_r <= spec_res;
`endif
            end
            ADDSUB: begin
               if (sign_l_r == sign_s_r)
                  sum_r <= {1'b0, mant_l_r} + {1'b0, mant_s_r};
               else
                  sum_r <= {1'b0, mant_l_r} - {1'b0, mant_s_r};
            end
            NORM: begin
               if (sum_r[MANT_W])
                  result_r <= pack_fp32(sign_l_r, exp_r + 9'd1,
                                        sum_r[MANT_W-1:1]);
               else if (sum_r == '0)
                  result_r <= {ZERO_SIGN, 31'h0};
               else if (sum_r[MANT_W-1])
                  result_r <= pack_fp32(sign_l_r, exp_r,
                                        sum_r[FRAC_W-1:0]);
               else if (exp_r <= 9'd1)
                  result_r <= {sign_l_r, 31'h0};
               else begin
                  sum_r <= sum_r << 1;
                  exp_r <= exp_r - 9'd1;
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// Directed scoreboard bench for fp32_subtractor_seq.
// Expected results are queued at issue and popped at out_valid.
module tb_fp32_subtractor_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fp32_subtractor_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] ai,
                         input logic [31:0] bi, input logic [31:0] ev,
                         input int lat, input int hold);
      int cnt;
      logic [31:0] want;
      logic [31:0] held;
      @(negedge clk);
      chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      a = ai;
      b = bi;
      in_valid = 1'b1;
      exp_q.push_back(ev);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end while (!out_valid && cnt < 40);
      chk({tag, "/latency"}, 32'(cnt), 32'(lat));
      if (exp_q.size() == 0)
         want = 32'hxxxxxxxx;
      else
         want = exp_q.pop_front();
      chk({tag, "/result"}, result, want);
      held = want;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            a = 32'h3F800000;
            b = 32'h3F800000;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk({tag, "/hold_result"}, result, held);
         chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "/post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/post_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "/post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst/in_ready", 32'(in_ready), 32'd1);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/result", result, 32'h0);
      rst_n = 1'b1;

      run_op("3m1", 32'h40400000, 32'h3F800000, 32'h40000000, 3, 0);
      run_op("1mneg1", 32'h3F800000, 32'hBF800000, 32'h40000000, 3, 0);
      run_op("1m1", 32'h3F800000, 32'h3F800000, 32'h00000000, 3, 0);
      run_op("cancel23", 32'h3F800000, 32'h3F800001, 32'hB4000000, 26, 0);
      run_op("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3, 0);
      run_op("2m3", 32'h40000000, 32'h40400000, 32'hBF800000, 4, 0);
      run_op("0m1p5", 32'h00000000, 32'h3FC00000, 32'hBFC00000, 3, 0);
      run_op("uflow", 32'h00800000, 32'h00800001, 32'h80000000, 3, 0);
      run_op("shift24", 32'h4B800000, 32'h3F800000, 32'h4B800000, 3, 0);
      run_op("shift23", 32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 4, 0);
      run_op("hold", 32'h40400000, 32'h3F800000, 32'h40000000, 3, 5);

      // Reset in the middle of the long normalise.
      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h3F800001;
      in_valid = 1'b1;
      exp_q.push_back(32'hB4000000);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("midrst/busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      chk("midrst/out_valid", 32'(out_valid), 32'd0);
      chk("midrst/result", result, 32'h0);
      chk("midrst/in_ready", 32'(in_ready), 32'd1);
      chk("midrst/busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 3, 0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
